ppu_line_fetcher: RTL and testbench

- Line-prefetch stage directly upstream of the VGA timing/colour output stage.
- During line N-1, fetches the tile map and 2bpp pattern rows for line N from video memory over a req/ack bus into the back bank of a double-buffered line buffer.
- During line N, serves registered RGB332 pixels from the front bank, indexed by the pixel counter.
- Sits between video memory and the 800x600@72Hz scan-out logic.

---
 rtl/ppu_pkg.sv | 29 ++
 rtl/ppu_line_ram.sv | 29 ++
 rtl/ppu_line_fetcher.sv | 188 ++++++++++++++++++
 tb/tb_ppu_line_fetcher.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types and helpers for the PPU line-prefetch path.
package ppu_pkg;

  typedef logic [7:0] rgb332_t;

  localparam int TILE_W = 8;
  localparam int BPP    = 2;

  localparam logic [15:0] MAP_BASE_DEF   = 16'h0000;
  localparam logic [15:0] PAT_BASE_DEF   = 16'h4000;
  localparam int          MAP_STRIDE_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAP  = 2'd1,
    ST_PAT  = 2'd2
  } fetch_state_e;

  // Palette entry k lives in pal[8k+7:8k].
  function automatic rgb332_t pal_entry(input logic [31:0] pal, input logic [1:0] idx);
    return pal[{idx, 3'b000} +: 8];
  endfunction

  // Leftmost pixel of a tile row sits in bits [15:14], rightmost in [1:0].
  function automatic logic [1:0] pix_field(input logic [15:0] row, input logic [2:0] col);
    return row[{~col, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ppu_line_ram.sv
// Double-banked line buffer: one write port, one synchronous read port.
module ppu_line_ram #(
  parameter int DEPTH = 100,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic          re_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2][DEPTH];

  // Write port: one tile row per fetch completion.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
  end

  // Read port: registered output, only updated on a valid in-range read.
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[rbank_i][raddr_i];
  end

endmodule

// File: rtl/ppu_line_fetcher.sv
// Prefetches the next scanline's tile rows into the back bank and serves
// RGB332 pixels from the front bank.
module ppu_line_fetcher
  import ppu_pkg::*;
#(
  parameter int          H_PIXELS   = 800,
  parameter logic [15:0] MAP_BASE   = MAP_BASE_DEF,
  parameter logic [15:0] PAT_BASE   = PAT_BASE_DEF,
  parameter int          MAP_STRIDE = MAP_STRIDE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_req,
  input  logic [9:0]  line_y,
  input  logic        line_swap,
  input  logic        rd_en,
  input  logic [9:0]  rd_x,
  input  logic [31:0] palette,
  output logic [7:0]  pix_color,
  output logic        line_ready,
  output logic        busy,
  output logic        underrun,
  output logic        overrun,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  localparam int            TILES   = H_PIXELS / TILE_W;
  localparam int            AW      = $clog2(TILES);
  localparam logic [AW-1:0] LAST_TX = AW'(TILES - 1);

  fetch_state_e  state_q, state_d;
  logic [9:0]    y_q, y_d;
  logic [AW-1:0] tx_q, tx_d;
  logic [7:0]    tile_q, tile_d;
  logic          busy_q, busy_d;
  logic          line_ready_q, line_ready_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;
  logic          front_q, front_d;
  logic          mem_req_q, mem_req_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic          rd_vld_q;
  logic [2:0]    rd_col_q;

  logic          ack;
  logic          start;
  logic          done;
  logic          ram_we;
  logic          rd_hit;
  logic [15:0]   map_addr;
  logic [15:0]   pat_addr;
  logic [15:0]   ram_rdata;

  // An ack only counts against an outstanding request.
  assign ack   = mem_ack & mem_req_q;
  assign start = line_req & (state_q == ST_IDLE);

  assign map_addr = MAP_BASE + 16'(y_q[9:3]) * 16'(MAP_STRIDE) + 16'(tx_q);
  assign pat_addr = PAT_BASE + {5'b0, tile_q, 3'b000} + {13'b0, y_q[2:0]};

  assign rd_hit = rd_en && (32'(rd_x) < H_PIXELS);

  // Control state: FSM, status flags, bank select and bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      line_ready_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
      front_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 16'h0000;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      line_ready_q <= line_ready_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
      front_q      <= front_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      rd_vld_q     <= rd_hit;
    end
  end

  // Fetch datapath registers; always loaded before use, so no reset.
  always_ff @(posedge clk) begin
    y_q      <= y_d;
    tx_q     <= tx_d;
    tile_q   <= tile_d;
    rd_col_q <= rd_x[2:0];
  end

  // Next-state: walk map word then pattern row for each tile column.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    tx_d    = tx_q;
    tile_d  = tile_q;
    ram_we  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_req) begin
          y_d     = line_y;
          tx_d    = '0;
          state_d = ST_MAP;
        end
      end
      ST_MAP: begin
        if (ack) begin
          tile_d  = mem_data[7:0];
          state_d = ST_PAT;
        end
      end
      ST_PAT: begin
        if (ack) begin
          ram_we = 1'b1;
          if (tx_q == LAST_TX) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tx_d    = tx_q + 1'b1;
            state_d = ST_MAP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: request drops for the cycle after an ack, then reissues with the new address.
  always_comb begin
    front_d      = front_q ^ line_swap;
    underrun_d   = underrun_q | (line_swap & busy_q);
    overrun_d    = overrun_q | (line_req & busy_q);
    busy_d       = (state_d != ST_IDLE);
    line_ready_d = line_ready_q | done;
    if (start || line_swap) line_ready_d = 1'b0;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_MAP: begin
        mem_req_d  = ~ack;
        mem_addr_d = map_addr;
      end
      ST_PAT: begin
        mem_req_d  = ~ack;
        mem_addr_d = pat_addr;
      end
      default: ;
    endcase
  end

  ppu_line_ram #(
    .DEPTH (TILES),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .wbank_i (~front_q),
    .waddr_i (tx_q),
    .wdata_i (mem_data),
    .re_i    (rd_hit),
    .rbank_i (front_q),
    .raddr_i (rd_x[3 +: AW]),
    .rdata_o (ram_rdata)
  );

  // Pixel lookup on the registered RAM word; blank when the read was invalid.
  always_comb begin
    pix_color = 8'h00;
    if (rd_vld_q) pix_color = pal_entry(palette, pix_field(ram_rdata, rd_col_q));
  end

  assign line_ready = line_ready_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_ppu_line_fetcher.sv
// Directed/randomised bench for ppu_line_fetcher with a behavioural video memory.
module tb_ppu_line_fetcher;

  localparam int H     = 800;
  localparam int TILES = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        line_req = 1'b0;
  logic [9:0]  line_y = '0;
  logic        line_swap = 1'b0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_x = '0;
  logic [31:0] palette = '0;
  logic [7:0]  pix_color;
  logic        line_ready;
  logic        busy;
  logic        underrun;
  logic        overrun;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] vmem [0:65535];
  logic [15:0] addr_log [$];
  logic [15:0] front_line [TILES];
  logic [15:0] back_line [TILES];

  int          max_dly = 0;
  bit          hold_ack = 1'b0;
  bit          spurious_ack = 1'b0;

  ppu_line_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .line_req   (line_req),
    .line_y     (line_y),
    .line_swap  (line_swap),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .palette    (palette),
    .pix_color  (pix_color),
    .line_ready (line_ready),
    .busy       (busy),
    .underrun   (underrun),
    .overrun    (overrun),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] map_a(input logic [9:0] y, input int tx);
    return 16'(32'(y >> 3) * 128 + tx);
  endfunction

  function automatic logic [15:0] pat_a(input logic [9:0] y, input logic [7:0] tile);
    return 16'(32'h4000 + 32'(tile) * 8 + 32'(y % 10'd8));
  endfunction

  function automatic logic [7:0] exp_pix(input int x);
    logic [15:0] w;
    int          idx;
    if (x >= H) return 8'h00;
    w   = front_line[x / 8];
    idx = int'((w >> (14 - 2 * (x % 8))) & 16'd3);
    return 8'((palette >> (8 * idx)) & 32'hFF);
  endfunction

  // Video memory: acks each request after a random 0..max_dly wait.
  initial forever begin
    bit          pending;
    int          wait_cnt;
    logic [15:0] hold_addr;
    @(negedge clk);
    if (rst || !mem_req) begin
      pending  = 1'b0;
      mem_ack  = spurious_ack;
      mem_data = 16'($urandom);
    end else begin
      if (!pending) begin
        pending   = 1'b1;
        wait_cnt  = int'($urandom_range(max_dly, 0));
        hold_addr = mem_addr;
      end else begin
        chk("addr_stable", mem_addr, hold_addr);
      end
      if (!hold_ack && wait_cnt == 0) begin
        mem_ack  = 1'b1;
        mem_data = vmem[mem_addr];
        addr_log.push_back(mem_addr);
        pending  = 1'b0;
      end else begin
        mem_ack = 1'b0;
        if (!hold_ack) wait_cnt--;
      end
    end
  end

  task automatic start_fetch(input logic [9:0] y, input int dly, input bit swap_too, input string tag);
    max_dly = dly;
    addr_log.delete();
    @(negedge clk);
    line_req  = 1'b1;
    line_y    = y;
    line_swap = swap_too;
    @(posedge clk); #1;
    line_req  = 1'b0;
    line_swap = 1'b0;
    chk({tag, ":busy_start"}, busy, 1);
    chk({tag, ":ready_clr"}, line_ready, 0);
  endtask

  task automatic finish_fetch(input logic [9:0] y, input bit chk_time, input string tag);
    int          n;
    logic [15:0] ma;
    logic [15:0] pa;
    logic [15:0] got;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":busy_end"}, busy, 0);
    if (chk_time) chk({tag, ":cycles"}, n, 400);
    chk({tag, ":line_ready"}, line_ready, 1);
    chk({tag, ":n_req"}, addr_log.size(), 200);
    for (int tx = 0; tx < TILES; tx++) begin
      ma  = map_a(y, tx);
      pa  = pat_a(y, vmem[ma][7:0]);
      got = (2 * tx < addr_log.size()) ? addr_log[2 * tx] : 16'hxxxx;
      chk({tag, ":map_addr"}, got, ma);
      got = (2 * tx + 1 < addr_log.size()) ? addr_log[2 * tx + 1] : 16'hxxxx;
      chk({tag, ":pat_addr"}, got, pa);
      back_line[tx] = vmem[pa];
    end
  endtask

  task automatic do_swap(input string tag);
    @(negedge clk);
    line_swap = 1'b1;
    @(posedge clk); #1;
    line_swap = 1'b0;
    chk({tag, ":ready_clr"}, line_ready, 0);
    front_line = back_line;
  endtask

  task automatic read_px(input logic [9:0] x, input bit en, output logic [7:0] px);
    @(negedge clk);
    rd_en = en;
    rd_x  = x;
    @(posedge clk); #1;
    px    = pix_color;
    rd_en = 1'b0;
  endtask

  task automatic read_all(input string tag);
    logic [7:0] px;
    for (int x = 0; x < H; x++) begin
      read_px(10'(x), 1'b1, px);
      chk(tag, px, exp_pix(x));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  px;
    logic [9:0]  y;
    int          n;

    for (int i = 0; i < 65536; i++) vmem[i] = 16'($urandom);
    for (int tx = 0; tx < TILES; tx++) begin
      vmem[tx] = {8'hA5, 8'(tx)};
      vmem[16'h4000 + tx * 8] = 16'hE4E4;
    end
    palette = 32'hFFE01C03;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst:mem_req", mem_req, 0);
    chk("rst:mem_addr", mem_addr, 0);
    chk("rst:pix", pix_color, 0);
    chk("rst:line_ready", line_ready, 0);
    chk("rst:busy", busy, 0);
    chk("rst:underrun", underrun, 0);
    chk("rst:overrun", overrun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Acks with no request outstanding are ignored
    spurious_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur:busy", busy, 0);
    chk("spur:mem_req", mem_req, 0);
    chk("spur:ready", line_ready, 0);
    @(negedge clk) spurious_ack = 1'b0;

    // Line 0, immediate acks, known pattern
    start_fetch(10'd0, 0, 1'b0, "y0");
    finish_fetch(10'd0, 1'b1, "y0");
    do_swap("swap_y0");
    read_px(10'd0, 1'b1, px); chk("y0:px0", px, 8'hFF);
    read_px(10'd1, 1'b1, px); chk("y0:px1", px, 8'hE0);
    read_px(10'd2, 1'b1, px); chk("y0:px2", px, 8'h1C);
    read_px(10'd3, 1'b1, px); chk("y0:px3", px, 8'h03);
    read_all("y0:pix");

    // Reads outside the visible line or without strobe are blank
    read_px(10'd800, 1'b1, px);  chk("oob:x800", px, 0);
    read_px(10'd1023, 1'b1, px); chk("oob:x1023", px, 0);
    read_px(10'd5, 1'b0, px);    chk("rd_en0", px, 0);

    // Line 13: second tile row, pattern row 5
    start_fetch(10'd13, 0, 1'b0, "y13");
    finish_fetch(10'd13, 1'b1, "y13");
    chk("y13:first_map", addr_log.size() > 0 ? addr_log[0] : 16'hxxxx, 16'h0080);
    chk("y13:first_pat", addr_log.size() > 1 ? addr_log[1] : 16'hxxxx,
        16'h4000 + {5'b0, vmem[16'h0080][7:0], 3'b000} + 16'd5);

    // Line 0 again with random ack latency; buffer must match the zero-latency result
    start_fetch(10'd0, 5, 1'b0, "y0dly");
    finish_fetch(10'd0, 1'b0, "y0dly");
    do_swap("swap_y0dly");
    read_all("y0dly:pix");

    // Random line and palette
    palette = $urandom;
    y = 10'($urandom_range(1023, 0));
    start_fetch(y, 3, 1'b0, "yrnd");
    finish_fetch(y, 1'b0, "yrnd");
    do_swap("swap_yrnd");
    read_all("yrnd:pix");

    // line_req while busy: flagged, fetch unaffected
    chk("ovr:before", overrun, 0);
    start_fetch(10'd40, 2, 1'b0, "ovr");
    repeat (50) @(posedge clk);
    @(negedge clk);
    line_req = 1'b1;
    line_y   = 10'd7;
    @(posedge clk); #1;
    line_req = 1'b0;
    chk("ovr:flag", overrun, 1);
    chk("ovr:busy", busy, 1);
    finish_fetch(10'd40, 1'b0, "ovr");

    // line_swap while busy: flagged, fetch continues
    chk("und:before", underrun, 0);
    y = 10'($urandom_range(1023, 0));
    start_fetch(y, 1, 1'b0, "und");
    repeat (60) @(posedge clk);
    @(negedge clk);
    line_swap = 1'b1;
    @(posedge clk); #1;
    line_swap = 1'b0;
    chk("und:flag", underrun, 1);
    chk("und:ready", line_ready, 0);
    finish_fetch(y, 1'b0, "und");

    // Swap and request in the same cycle: fetch lands in the new back bank
    palette = $urandom;
    y = 10'($urandom_range(1023, 0));
    start_fetch(y, 0, 1'b1, "swreq");
    finish_fetch(y, 1'b1, "swreq");
    do_swap("swap_swreq");
    read_all("swreq:pix");
    chk("sticky:overrun", overrun, 1);
    chk("sticky:underrun", underrun, 1);

    // Reset while a pattern request is outstanding
    start_fetch(10'd77, 0, 1'b0, "prerst");
    n = 0;
    while (addr_log.size() < 5 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mrst:reach_tx2", addr_log.size(), 5);
    hold_ack = 1'b1;
    n = 0;
    while (mem_req !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mrst:pat_pending", mem_req, 1);
    chk("mrst:pat_addr", mem_addr, pat_a(10'd77, vmem[map_a(10'd77, 2)][7:0]));
    #2 rst = 1'b1;
    #1;
    chk("mrst:mem_req", mem_req, 0);
    chk("mrst:mem_addr", mem_addr, 0);
    chk("mrst:busy", busy, 0);
    chk("mrst:line_ready", line_ready, 0);
    chk("mrst:underrun", underrun, 0);
    chk("mrst:overrun", overrun, 0);
    chk("mrst:pix", pix_color, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    hold_ack = 1'b0;

    // Fetch after reset restarts from tile column 0
    y = 10'($urandom_range(1023, 0));
    start_fetch(y, 0, 1'b0, "postrst");
    finish_fetch(y, 1'b1, "postrst");
    do_swap("swap_postrst");
    read_all("postrst:pix");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
